// File: rtl/eeprom_writer.sv
// -----------------------------------------------------------------------------
// eeprom_writer
//
// Programs a parallel EEPROM one word at a time. A loader hands over
// address/data pairs on a valid/ready stream. Each word goes through four
// steps:
//   1. Drive the bus with the address and data, then strobe N_WE.
//   2. Turn the data bus around.
//   3. Poll the device with N_OE reads until the MSB of the read value
//      matches the MSB that was written.
//   4. Compare the full word.
// A matching word produces a one-cycle DONE. A mismatch, or a write that
// never completes within MAX_POLLS reads, parks the block in a sticky error
// state. Only RST leaves that state.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   IN_VALID/READY    request handshake (IN_READY decoded from state)
//   IN_ADDR, IN_DATA  word to program, latched on the handshake
//   ADDR, DATA_OUT    EEPROM address and write data (registered)
//   DATA_OE           enable for the external tristate driving DATA_OUT
//   DATA_IN           EEPROM data bus readback
//   N_CE, N_OE, N_WE  EEPROM strobes, active-low (registered)
//   BUSY              not idle (decoded from state)
//   DONE              one-cycle pulse: word written and verified
//   ERR               sticky verify/timeout error
// -----------------------------------------------------------------------------
module eeprom_writer #(
  parameter int DEPTH        = 17,
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int READ_CYCLES  = 2,
  parameter int MAX_POLLS    = 4096
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [DEPTH-1:0] IN_ADDR,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [DEPTH-1:0] ADDR,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_OE,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             N_CE,
  output logic             N_OE,
  output logic             N_WE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  // One shared phase counter serves every timed state, so it is sized for
  // the longest phase. It counts 0 .. N-1 within a phase.
  localparam int MAX_SP    = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_HR    = (HOLD_CYCLES > READ_CYCLES) ? HOLD_CYCLES : READ_CYCLES;
  localparam int MAX_PHASE = (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
  localparam int CYC_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam int POLL_W    = $clog2(MAX_POLLS + 1);

  localparam logic [CYC_W-1:0]  CYC_ONE     = CYC_W'(1);
  localparam logic [CYC_W-1:0]  SETUP_LAST  = CYC_W'(SETUP_CYCLES - 1);
  localparam logic [CYC_W-1:0]  PULSE_LAST  = CYC_W'(PULSE_CYCLES - 1);
  localparam logic [CYC_W-1:0]  HOLD_LAST   = CYC_W'(HOLD_CYCLES - 1);
  localparam logic [CYC_W-1:0]  READ_LAST   = CYC_W'(READ_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_ONE    = POLL_W'(1);
  localparam logic [POLL_W-1:0] MAX_POLLS_V = POLL_W'(MAX_POLLS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_TURN,
    S_POLL_RD,
    S_POLL_GAP,
    S_FIN,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [POLL_W-1:0] poll_inc;
  logic [DEPTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              n_ce_q, n_ce_d;
  logic              n_oe_q, n_oe_d;
  logic              n_we_q, n_we_d;
  logic              data_oe_q, data_oe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Gate with RST so that no request is taken while reset is held,
  // including the first reset cycle, before the state register is known.
  assign IN_READY = (state_q == S_IDLE) && !RST;
  assign BUSY     = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so that no path
    // through the case leaves one unassigned and infers a latch.
    state_d    = state_q;
    cyc_cnt_d  = '0;
    poll_cnt_d = poll_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    poll_inc   = (&poll_cnt_q) ? poll_cnt_q : poll_cnt_q + POLL_ONE;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID && IN_READY) begin
          addr_d     = IN_ADDR;
          data_d     = IN_DATA;
          poll_cnt_d = '0;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cyc_cnt_q == SETUP_LAST) state_d = S_PULSE;
        else                         cyc_cnt_d = cyc_cnt_q + CYC_ONE;
      end

      S_PULSE: begin
        if (cyc_cnt_q == PULSE_LAST) state_d = S_HOLD;
        else                         cyc_cnt_d = cyc_cnt_q + CYC_ONE;
      end

      S_HOLD: begin
        if (cyc_cnt_q == HOLD_LAST) state_d = S_TURN;
        else                        cyc_cnt_d = cyc_cnt_q + CYC_ONE;
      end

      S_TURN: state_d = S_POLL_RD;

      S_POLL_RD: begin
        if (cyc_cnt_q == READ_LAST) begin
          // DATA_IN is taken on the edge that ends the last read cycle.
          // While the device is still busy, it returns the complement of the
          // written MSB. Once the MSBs agree, the write has finished, and the
          // full word either matches or it does not.
          poll_cnt_d = poll_inc;
          if (DATA_IN[WIDTH-1] != data_q[WIDTH-1]) begin
            state_d = (poll_inc == MAX_POLLS_V) ? S_FAIL : S_POLL_GAP;
          end else if (DATA_IN == data_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_ONE;
        end
      end

      S_POLL_GAP: state_d = S_POLL_RD;

      S_FIN: state_d = S_IDLE;

      S_FAIL: state_d = S_FAIL;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. The strobes are a function of the state being entered, so
  // the registered pins line up with the state register without a cycle of
  // lag. As a result, N_WE can be low only in PULSE, and DATA_OE and N_OE
  // can never be active together.
  // ---------------------------------------------------------------------------
  always_comb begin
    n_ce_d    = 1'b1;
    n_oe_d    = 1'b1;
    n_we_d    = 1'b1;
    data_oe_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_d)
      S_SETUP, S_HOLD: begin
        n_ce_d    = 1'b0;
        data_oe_d = 1'b1;
      end
      S_PULSE: begin
        n_ce_d    = 1'b0;
        n_we_d    = 1'b0;
        data_oe_d = 1'b1;
      end
      S_TURN, S_POLL_GAP: n_ce_d = 1'b0;
      S_POLL_RD: begin
        n_ce_d = 1'b0;
        n_oe_d = 1'b0;
      end
      S_FIN:   done_d = 1'b1;
      S_FAIL:  err_d  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. ADDR and DATA_OUT come straight from the latched request. They
  // therefore stay put from the first SETUP cycle until the next handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    if (RST) begin
      state_q    <= S_IDLE;
      cyc_cnt_q  <= '0;
      poll_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      n_ce_q     <= 1'b1;
      n_oe_q     <= 1'b1;
      n_we_q     <= 1'b1;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      n_ce_q     <= n_ce_d;
      n_oe_q     <= n_oe_d;
      n_we_q     <= n_we_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ADDR     = addr_q;
  assign DATA_OUT = data_q;
  assign DATA_OE  = data_oe_q;
  assign N_CE     = n_ce_q;
  assign N_OE     = n_oe_q;
  assign N_WE     = n_we_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_eeprom_writer.sv
// -----------------------------------------------------------------------------
// tb_eeprom_writer
//
// Directed bench for eeprom_writer (MAX_POLLS reduced to 8).
//
// The EEPROM is modelled as a responder. It returns a "busy" value for the
// first N reads of a word and a final value after that.
//
// The expected pin values for each cycle come from the timing rules, given
// the offset from the handshake edge and the poll outcome. The bench works
// that outcome out from the responder settings.
// -----------------------------------------------------------------------------
module tb_eeprom_writer;

  localparam int DEPTH     = 17;
  localparam int WIDTH     = 8;
  localparam int S         = 2;
  localparam int P         = 4;
  localparam int H         = 2;
  localparam int R         = 2;
  localparam int MAX_POLLS = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DEPTH-1:0] in_addr;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] addr;
  logic [WIDTH-1:0] data_out;
  logic             data_oe;
  logic [WIDTH-1:0] data_in;
  logic             n_ce, n_oe, n_we, busy, done, err;

  always #5 clk = ~clk;

  eeprom_writer #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .SETUP_CYCLES(S), .PULSE_CYCLES(P),
    .HOLD_CYCLES(H), .READ_CYCLES(R), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_ADDR(in_addr), .IN_DATA(in_data), .ADDR(addr), .DATA_OUT(data_out),
    .DATA_OE(data_oe), .DATA_IN(data_in), .N_CE(n_ce), .N_OE(n_oe),
    .N_WE(n_we), .BUSY(busy), .DONE(done), .ERR(err)
  );

  // Pin vector order: n_ce n_oe n_we data_oe done err in_ready busy
  typedef struct packed {
    logic n_ce, n_oe, n_we, data_oe, done, err, in_ready, busy;
  } ctl_t;

  localparam ctl_t C_IDLE  = 8'b1110_0010;
  localparam ctl_t C_DRIVE = 8'b0111_0001;   // setup and hold
  localparam ctl_t C_PULSE = 8'b0101_0001;
  localparam ctl_t C_QUIET = 8'b0110_0001;   // turnaround and poll gap
  localparam ctl_t C_READ  = 8'b0010_0001;
  localparam ctl_t C_FIN   = 8'b1110_1001;
  localparam ctl_t C_FAIL  = 8'b1110_0101;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // during cycle c, cyc == c-1 (edge c ends cycle c)

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Current word, as seen by the model.
  bit               cmp_en = 1'b0;
  bit               txn_on = 1'b0;
  bit               txn_ok = 1'b0;
  int               txn_t = 0;
  int               txn_reads = 0;
  logic [DEPTH-1:0] txn_addr = '0;
  logic [WIDTH-1:0] txn_data = '0;

  // EEPROM responder.
  int               resp_base = 0;
  int               resp_busy = 0;
  logic [WIDTH-1:0] resp_busy_v = '0;
  logic [WIDTH-1:0] resp_final_v = '0;

  // Monitor counters.
  int   oe_falls = 0, done_cnt = 0, conflict_cnt = 0;
  int   done_cyc = -1, we_fall_cyc = -1, we_last_cyc = -1;
  logic prev_n_oe = 1'b1, prev_n_we = 1'b1;

  // Read k of the current word (1-based) sees the busy value while
  // k <= resp_busy.
  assign data_in = ((oe_falls - resp_base) <= resp_busy) ? resp_busy_v : resp_final_v;

  always @(negedge clk) begin
    prev_n_oe <= n_oe;
    prev_n_we <= n_we;
    if (!n_oe && prev_n_oe) oe_falls <= oe_falls + 1;
    if (!n_we && prev_n_we) we_fall_cyc <= cyc + 1;
    if (!n_we) we_last_cyc <= cyc + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc + 1;
    end
    if (data_oe && !n_oe) conflict_cnt <= conflict_cnt + 1;
  end

  // Expected pins k cycles after the handshake edge. Cycle k belongs to:
  //   1..S        setup
  //   S+1..S+P    write pulse
  //   ..S+P+H     hold
  //   S+P+H+1     turnaround
  //   then reads of R cycles, each followed by a gap, except the last.
  //   The cycle after the last read is FIN or FAIL.
  function automatic ctl_t model_ctl(input int k);
    int m;
    int last;
    if (!txn_on || k < 1) return C_IDLE;
    if (k <= S) return C_DRIVE;
    if (k <= S + P) return C_PULSE;
    if (k <= S + P + H) return C_DRIVE;
    if (k == S + P + H + 1) return C_QUIET;
    m    = k - (S + P + H + 2);
    last = txn_reads * (R + 1) - 1;
    if (m < last) return ((m % (R + 1)) < R) ? C_READ : C_QUIET;
    if (m == last) return txn_ok ? C_FIN : C_FAIL;
    return txn_ok ? C_IDLE : C_FAIL;
  endfunction

  int   cmp_k;
  ctl_t cmp_exp;
  ctl_t cmp_act;

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_k   = cyc + 1 - txn_t;
      cmp_exp = model_ctl(cmp_k);
      cmp_act = {n_ce, n_oe, n_we, data_oe, done, err, in_ready, busy};
      check("ctl_pins", 32'(cmp_act), 32'(cmp_exp));
      if (txn_on && cmp_k >= 1 && cmp_k <= S + P + H) begin
        check("addr_bus", 32'(addr), 32'(txn_addr));
        check("data_bus", 32'(data_out), 32'(txn_data));
      end
    end
  end

  // Called at edge+1. Holds reset for two cycles, checks reset values in the
  // second cycle, and returns at edge+1 with reset released.
  task automatic do_reset();
    rst      = 1'b1;
    cmp_en   = 1'b0;
    txn_on   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ctl_pins", 32'({n_ce, n_oe, n_we, data_oe, done, err, in_ready, busy}),
          32'(8'b1110_0000));
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
  endtask

  // Presents one word and works out its outcome from the responder rules.
  // IN_VALID stays high during the whole operation, with different
  // address/data, and must be ignored. On success it drops in the cycle
  // after FIN. A failing word keeps it high. abort_after > 0 raises RST in
  // cycle t+abort_after+1.
  task automatic write_word(input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d,
                            input int busy_n, input logic [WIDTH-1:0] busy_v,
                            input logic [WIDTH-1:0] final_v, input int abort_after,
                            output int t_hs);
    int               n;
    bit               ok;
    logic [WIDTH-1:0] v;
    n  = MAX_POLLS;
    ok = 1'b0;
    for (int j = 0; j < MAX_POLLS; j++) begin
      v = (j < busy_n) ? busy_v : final_v;
      if (v[WIDTH-1] == d[WIDTH-1]) begin
        n  = j + 1;
        ok = (v == d);
        break;
      end
    end
    resp_base    = oe_falls;
    resp_busy    = busy_n;
    resp_busy_v  = busy_v;
    resp_final_v = final_v;
    txn_t        = cyc + 1;
    txn_reads    = n;
    txn_ok       = ok;
    txn_addr     = a;
    txn_data     = d;
    txn_on       = 1'b1;
    in_valid     = 1'b1;
    in_addr      = a;
    in_data      = d;
    @(posedge clk);
    #1;
    t_hs    = txn_t;
    in_addr = ~a;
    in_data = ~d;
    if (abort_after > 0) begin
      repeat (abort_after) begin
        @(posedge clk);
        #1;
      end
      rst      = 1'b1;
      cmp_en   = 1'b0;
      txn_on   = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_still_pulsing", 32'(n_we), 32'h0);
      @(negedge clk);
      check("abort_ctl", 32'({n_ce, n_oe, n_we, data_oe, done, err}), 32'(6'b111000));
      @(posedge clk);
      #1;
      rst    = 1'b0;
      cmp_en = 1'b1;
    end else begin
      repeat (S + P + H + 1 + n * (R + 1)) begin
        @(posedge clk);
        #1;
      end
      if (ok) in_valid = 1'b0;
    end
  endtask

  int t1, t2, t3, t4, t5, t6, d0, f0;

  initial begin
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    rst      = 1'b1;
    do_reset();

    // Immediate success.
    d0 = done_cnt;
    write_word(17'h1ABCD, 8'hA5, 0, 8'h00, 8'hA5, 0, t1);
    check("t1_we_first", 32'(we_fall_cyc - t1), 32'd3);
    check("t1_we_last", 32'(we_last_cyc - t1), 32'd6);
    check("t1_done_offset", 32'(done_cyc - t1), 32'd12);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // Three busy polls, then success. Requested back-to-back with word 1.
    f0 = oe_falls;
    write_word(17'h00F0F, 8'hA5, 3, 8'h25, 8'hA5, 0, t2);
    check("b2b_spacing", 32'(t2 - t1), 32'd13);
    check("t2_oe_pulses", 32'(oe_falls - f0), 32'd4);
    check("t2_done_offset", 32'(done_cyc - t2), 32'd21);

    // Reset in the second PULSE cycle, then a normal write.
    d0 = done_cnt;
    write_word(17'h05555, 8'h3C, 0, 8'h00, 8'h3C, 3, t3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_err", 32'(err), 32'h0);
    write_word(17'h0AAAA, 8'h5A, 1, 8'hDA, 8'h5A, 0, t4);
    check("t4_done_offset", 32'(done_cyc - t4), 32'd15);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);

    // Verify failure: the MSB matches, the low bit does not.
    d0 = done_cnt;
    write_word(17'h00001, 8'hA5, 0, 8'h00, 8'hA4, 0, t5);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("vf_err", 32'(err), 32'h1);
    check("vf_ready_low", 32'(in_ready), 32'h0);
    check("vf_no_done", 32'(done_cnt - d0), 32'd0);
    do_reset();

    // Poll timeout: the device never finishes.
    f0 = oe_falls;
    write_word(17'h1FFFF, 8'hA5, 1000, 8'h25, 8'h00, 0, t6);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("to_oe_pulses", 32'(oe_falls - f0), 32'd8);
    check("to_err", 32'(err), 32'h1);
    do_reset();

    // ERR has been cleared by the reset. A fresh word works again.
    write_word(17'h00002, 8'h11, 0, 8'h00, 8'h11, 0, t1);
    check("final_done_offset", 32'(done_cyc - t1), 32'd12);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("oe_drive_conflicts", 32'(conflict_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eeprom_writer.md
# eeprom_writer

- Programs a parallel EEPROM one word at a time. Accepts address/data words on a valid/ready stream and drives the EEPROM's ADDR, data bus, N_CE, N_WE and N_OE with parameterised write timing.
- Confirms each write by data polling on the MSB, then verifies the full word.
- Sits between the boot/programming loader and the EEPROM. It is the write-side counterpart to the read-only eeprom model.

## Interface
Parameters:
- DEPTH, 17, address width
- WIDTH, 8, data width
- SETUP_CYCLES, 2, ADDR/DATA valid before N_WE falls (≥1)
- PULSE_CYCLES, 4, N_WE low width (≥1)
- HOLD_CYCLES, 2, DATA held after N_WE rises (≥1)
- READ_CYCLES, 2, N_OE low per poll read (≥1)
- MAX_POLLS, 4096, poll reads before timeout (≥1)

Ports (clock and reset first):
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- IN_VALID  in  1  write request valid
- IN_READY  out  1  block can accept a request
- IN_ADDR  in  DEPTH  target address
- IN_DATA  in  WIDTH  data to write
- ADDR  out  DEPTH  EEPROM address
- DATA_OUT  out  WIDTH  value for the EEPROM data bus
- DATA_OE  out  1  enables the external tristate driver for DATA_OUT
- DATA_IN  in  WIDTH  EEPROM data bus readback
- N_CE  out  1  chip enable, active-low
- N_OE  out  1  output enable, active-low
- N_WE  out  1  write enable, active-low
- BUSY  out  1  not in IDLE
- DONE  out  1  one-cycle pulse: word written and verified
- ERR  out  1  sticky: verify mismatch or poll timeout; cleared only by RST

## Operation
- All outputs are registered except IN_READY and BUSY, which are decoded from state.
- States: IDLE, SETUP, PULSE, HOLD, TURN, POLL_RD, POLL_GAP, FIN, FAIL.
- IDLE
  - IN_READY=1. N_CE=N_OE=N_WE=1, DATA_OE=0.
  - On IN_VALID&&IN_READY: latch IN_ADDR/IN_DATA, clear the poll counter, go to SETUP.
- SETUP
  - ADDR=latched address, DATA_OUT=latched data, DATA_OE=1, N_CE=0.
  - N_WE=1, N_OE=1, for SETUP_CYCLES cycles.
- PULSE: as SETUP but N_WE=0, for PULSE_CYCLES cycles.
- HOLD: N_WE=1, DATA_OE=1, for HOLD_CYCLES cycles.
- TURN: DATA_OE=0, N_OE=1, N_CE=0 for 1 cycle. This is the bus turnaround.
- POLL_RD
  - N_OE=0, DATA_OE=0, for READ_CYCLES cycles.
  - DATA_IN is sampled on the edge ending the last cycle.
  - The poll counter increments by 1 (saturating width $clog2(MAX_POLLS+1)).
- Decision on each sample:
  - Sample MSB ≠ latched MSB (write still in progress):
    - if poll counter == MAX_POLLS, go to FAIL;
    - otherwise go to POLL_GAP.
  - Sample MSB == latched MSB:
    - full word equal: go to FIN;
    - otherwise: go to FAIL.
- POLL_GAP: N_OE=1, N_CE=0 for 1 cycle, then POLL_RD.
- FIN: DONE=1, N_CE=N_OE=1 for 1 cycle, then IDLE.
- FAIL
  - ERR=1, N_CE=N_OE=N_WE=1, DATA_OE=0, IN_READY=0.
  - Stays in FAIL until RST.
- Invariants:
  - DATA_OE=1 and N_OE=0 are never true in the same cycle.
  - N_WE=0 only in PULSE.
  - ADDR and DATA_OUT are stable from the first SETUP cycle through the last HOLD cycle.
- IN_ADDR/IN_DATA changes after the handshake are ignored.
- IN_VALID while busy is not accepted; the request is held by the source.

## Timing
- Reset values (the cycle after RST sampled high):
  - N_CE=N_OE=N_WE=1, DATA_OE=0, ADDR=0, DATA_OUT=0, DONE=0, ERR=0.
  - State=IDLE. IN_READY=0 while RST=1.
- Handshake at edge t: first SETUP cycle is t+1. With S/P/H/R = SETUP/PULSE/HOLD/READ cycles:
  - N_WE is low in cycles t+S+1 … t+S+P.
  - First sample is at the end of cycle t+S+P+H+1+R.
- Latency:
  - Immediate success: DONE in cycle t+S+P+H+R+2 (12 with defaults).
  - Each extra poll adds R+1 cycles (3 with defaults).
- Next handshake is possible in the cycle after FIN. Back-to-back IN_VALID gives one word per 13 cycles minimum.
- RST mid-operation (any state): next cycle all outputs are at reset values, N_WE=1, DATA_OE=0. No DONE and no ERR for the aborted word.

## Test plan
- Reset: RST high 2 cycles.
  - During reset: IN_READY=0, N_CE=N_OE=N_WE=1, DATA_OE=0.
  - The cycle after RST falls: IN_READY=1.
- Immediate success: write ADDR=0x1ABCD, DATA=0xA5; model returns 0xA5.
  - N_WE low exactly cycles t+3…t+6.
  - ADDR=0x1ABCD and DATA_OUT=0xA5 throughout SETUP–HOLD.
  - DONE at t+12.
- Polling: model returns 0x25 for 3 reads, then 0xA5.
  - 4 N_OE falling edges.
  - DONE at t+21.
  - DATA_OE && !N_OE never observed.
- Verify fail: model returns 0xA4.
  - ERR=1 after first sample, DONE never pulses.
  - IN_READY stays 0 until RST.
- Timeout: MAX_POLLS=8, model always returns 0x25.
  - Exactly 8 N_OE pulses, then ERR=1.
- Reset mid-PULSE: assert RST in the 2nd PULSE cycle.
  - Next cycle: N_WE=1, DATA_OE=0.
  - No DONE.
  - A subsequent write completes normally.
